// File: rtl/sram_matrix_reader.sv
// sram_matrix_reader: bus master for a single-port sync_ram.
// On start it polls the flag word, decodes the dimension header and checks
// the dimensions, streams A then B row-major over a valid/ready handshake,
// then clears the flag word and pulses done.
// Ports: clk, rst (async, active high), start; mem_addr/mem_read/mem_we/
//   mem_din/mem_dout to the RAM; a_rows/a_cols/b_rows/b_cols and dims_valid;
//   elem_data/elem_sel/elem_row/elem_col/elem_valid/elem_ready to the
//   consumer; busy, done and error status.
// Optional: define SRAM_READER_POLL_TIMEOUT_EN to give up polling after
//   POLL_LIMIT reads of a clear flag.
module sram_matrix_reader #(
   parameter int ADDR_WIDTH = 16,
   parameter int FLAG_ADDR  = 0,
   parameter int HDR_ADDR   = 1,
   parameter int A_BASE     = 2,
   parameter int B_BASE     = 10002,
   parameter int POLL_LIMIT = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read,
   output logic                  mem_we,
   output logic [31:0]           mem_din,
   input  logic [31:0]           mem_dout,
   output logic [7:0]            a_rows,
   output logic [7:0]            a_cols,
   output logic [7:0]            b_rows,
   output logic [7:0]            b_cols,
   output logic                  dims_valid,
   output logic [31:0]           elem_data,
   output logic                  elem_sel,
   output logic [7:0]            elem_row,
   output logic [7:0]            elem_col,
   output logic                  elem_valid,
   input  logic                  elem_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_POLL    = 4'd1;
   localparam logic [3:0] S_HDR     = 4'd2;
   localparam logic [3:0] S_CHECK   = 4'd3;
   localparam logic [3:0] S_FETCH_A = 4'd4;
   localparam logic [3:0] S_FETCH_B = 4'd5;
   localparam logic [3:0] S_DRAIN   = 4'd6;
   localparam logic [3:0] S_CLEAR   = 4'd7;
   localparam logic [3:0] S_DONE    = 4'd8;

   localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [3:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            row_q, row_d, col_q, col_d;
   logic [7:0]            a_rows_q, a_rows_d, a_cols_q, a_cols_d;
   logic [7:0]            b_rows_q, b_rows_d, b_cols_q, b_cols_d;
   logic                  dims_valid_q, dims_valid_d;
   logic                  error_q, error_d;
   logic [31:0]           elem_data_q, elem_data_d;
   logic                  elem_sel_q, elem_sel_d;
   logic [7:0]            elem_row_q, elem_row_d, elem_col_q, elem_col_d;
   logic                  elem_valid_q, elem_valid_d;
   logic                  slot_free, is_b;
   logic [7:0]            lim_rows, lim_cols;
`ifdef SRAM_READER_POLL_TIMEOUT_EN
   logic [31:0]           poll_cnt_q, poll_cnt_d;
`else
   logic                  unused_poll_limit;
   assign unused_poll_limit = ^POLL_LIMIT;
`endif

   assign slot_free = !elem_valid_q || elem_ready;
   assign is_b      = (state_q == S_FETCH_B);
   assign lim_rows  = is_b ? b_rows_q : a_rows_q;
   assign lim_cols  = is_b ? b_cols_q : a_cols_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      row_d        = row_q;
      col_d        = col_q;
      a_rows_d     = a_rows_q;
      a_cols_d     = a_cols_q;
      b_rows_d     = b_rows_q;
      b_cols_d     = b_cols_q;
      dims_valid_d = dims_valid_q;
      error_d      = error_q;
      elem_data_d  = elem_data_q;
      elem_sel_d   = elem_sel_q;
      elem_row_d   = elem_row_q;
      elem_col_d   = elem_col_q;
      elem_valid_d = elem_valid_q;
`ifdef SRAM_READER_POLL_TIMEOUT_EN
      poll_cnt_d   = poll_cnt_q;
`endif
      mem_addr     = '0;
      mem_read     = 1'b0;
      mem_we       = 1'b0;
      mem_din      = '0;
      // A completed handshake empties the slot unless refilled below.
      if (elem_valid_q && elem_ready) begin
         elem_valid_d = 1'b0;
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               error_d      = 1'b0;
               dims_valid_d = 1'b0;
               state_d      = S_POLL;
`ifdef SRAM_READER_POLL_TIMEOUT_EN
               poll_cnt_d   = '0;
`endif
            end
         end
         S_POLL: begin
            mem_read = 1'b1;
            mem_addr = ADDR_WIDTH'(FLAG_ADDR);
            if (mem_dout[0]) begin
               state_d = S_HDR;
            end
`ifdef SRAM_READER_POLL_TIMEOUT_EN
            else if (poll_cnt_q == 32'(POLL_LIMIT - 1)) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               poll_cnt_d = poll_cnt_q + 32'd1;
            end
`endif
         end
         S_HDR: begin
            mem_read = 1'b1;
            mem_addr = ADDR_WIDTH'(HDR_ADDR);
            b_rows_d = mem_dout[31:24];
            b_cols_d = mem_dout[23:16];
            a_rows_d = mem_dout[15:8];
            a_cols_d = mem_dout[7:0];
            state_d  = S_CHECK;
         end
         S_CHECK: begin
            if (a_rows_q == 8'd0 || a_cols_q == 8'd0 ||
                b_rows_q == 8'd0 || b_cols_q == 8'd0 ||
                b_cols_q != a_rows_q) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               dims_valid_d = 1'b1;
               addr_d       = ADDR_WIDTH'(A_BASE);
               row_d        = '0;
               col_d        = '0;
               state_d      = S_FETCH_A;
            end
         end
         S_FETCH_A, S_FETCH_B: begin
            if (slot_free) begin
               mem_read     = 1'b1;
               mem_addr     = addr_q;
               elem_data_d  = mem_dout;
               elem_sel_d   = is_b;
               elem_row_d   = row_q;
               elem_col_d   = col_q;
               elem_valid_d = 1'b1;
               addr_d       = addr_q + ONE;
               if (col_q == lim_cols - 8'd1) begin
                  col_d = '0;
                  if (row_q == lim_rows - 8'd1) begin
                     row_d = '0;
                     if (is_b) begin
                        state_d = S_DRAIN;
                     end else begin
                        addr_d  = ADDR_WIDTH'(B_BASE);
                        state_d = S_FETCH_B;
                     end
                  end else begin
                     row_d = row_q + 8'd1;
                  end
               end else begin
                  col_d = col_q + 8'd1;
               end
            end
         end
         S_DRAIN: begin
            if (slot_free) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = ADDR_WIDTH'(FLAG_ADDR);
            mem_din  = '0;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         row_q        <= '0;
         col_q        <= '0;
         a_rows_q     <= '0;
         a_cols_q     <= '0;
         b_rows_q     <= '0;
         b_cols_q     <= '0;
         dims_valid_q <= 1'b0;
         error_q      <= 1'b0;
         elem_data_q  <= '0;
         elem_sel_q   <= 1'b0;
         elem_row_q   <= '0;
         elem_col_q   <= '0;
         elem_valid_q <= 1'b0;
`ifdef SRAM_READER_POLL_TIMEOUT_EN
         poll_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         row_q        <= row_d;
         col_q        <= col_d;
         a_rows_q     <= a_rows_d;
         a_cols_q     <= a_cols_d;
         b_rows_q     <= b_rows_d;
         b_cols_q     <= b_cols_d;
         dims_valid_q <= dims_valid_d;
         error_q      <= error_d;
         elem_data_q  <= elem_data_d;
         elem_sel_q   <= elem_sel_d;
         elem_row_q   <= elem_row_d;
         elem_col_q   <= elem_col_d;
         elem_valid_q <= elem_valid_d;
`ifdef SRAM_READER_POLL_TIMEOUT_EN
         poll_cnt_q   <= poll_cnt_d;
`endif
      end
   end

   assign a_rows     = a_rows_q;
   assign a_cols     = a_cols_q;
   assign b_rows     = b_rows_q;
   assign b_cols     = b_cols_q;
   assign dims_valid = dims_valid_q;
   assign error      = error_q;
   assign elem_data  = elem_data_q;
   assign elem_sel   = elem_sel_q;
   assign elem_row   = elem_row_q;
   assign elem_col   = elem_col_q;
   assign elem_valid = elem_valid_q;
   assign done       = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_sram_matrix_reader.sv
// tb_sram_matrix_reader: random-data scoreboard bench for sram_matrix_reader.
// Holds the RAM model, a row-major reference queue and a beat monitor.
module tb_sram_matrix_reader;

   typedef struct packed {
      logic        sel;
      logic [7:0]  row;
      logic [7:0]  col;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        elem_ready = 1'b0;
   logic [15:0] mem_addr;
   logic        mem_read, mem_we;
   logic [31:0] mem_din, mem_dout;
   logic [7:0]  a_rows, a_cols, b_rows, b_cols;
   logic        dims_valid;
   logic [31:0] elem_data;
   logic        elem_sel;
   logic [7:0]  elem_row, elem_col;
   logic        elem_valid, busy, done, error;

   sram_matrix_reader dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_we(mem_we),
      .mem_din(mem_din), .mem_dout(mem_dout),
      .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
      .dims_valid(dims_valid), .elem_data(elem_data), .elem_sel(elem_sel),
      .elem_row(elem_row), .elem_col(elem_col), .elem_valid(elem_valid),
      .elem_ready(elem_ready), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:65535];
   assign mem_dout = mem_read ? mem[mem_addr] : 32'h0;

   int total = 0;
   int bad = 0;
   int poll_reads = 0;
   int flag_writes = 0;
   int done_cnt = 0;
   int both_cnt = 0;
   int valid_cnt = 0;
   int beats = 0;
   int cyc = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   int ready_mode = 0;
   bit inject = 1'b0;
   bit held = 1'b0;
   beat_t held_beat;
   beat_t exp_q[$];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] = mem_din;
         if (mem_addr == 16'd0) flag_writes++;
      end
      if (mem_read && mem_addr == 16'd0) poll_reads++;
   end

   initial begin
      int rc;
      rc = 0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0: elem_ready = 1'b1;
            1: elem_ready = (rc % 3 == 0);
            default: elem_ready = 1'($urandom_range(0, 1));
         endcase
         rc++;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (inject && elem_valid && elem_sel) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            inject = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      beat_t cur, e;
      cyc++;
      if (mem_read && mem_we) both_cnt++;
      if (done) done_cnt++;
      cur = '{elem_sel, elem_row, elem_col, elem_data};
      if (!rst && elem_valid) begin
         valid_cnt++;
         if (held) begin
            total++;
            if (cur !== held_beat) begin
               bad++;
               $display("FAIL stall_hold: got %h want %h", cur, held_beat);
            end
         end
         if (elem_ready) begin
            held = 1'b0;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_beat: got %h want none", cur);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  bad++;
                  $display("FAIL beat%0d: got %h want %h", beats, cur, e);
               end
            end
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
         end else begin
            held = 1'b1;
            held_beat = cur;
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   task automatic prep(input logic [7:0] br, input logic [7:0] bc,
                       input logic [7:0] ar, input logic [7:0] ac,
                       input logic [31:0] flag, input bit push);
      logic [31:0] v;
      mem[0] = flag;
      mem[1] = {br, bc, ar, ac};
      for (int r = 0; r < int'(ar); r++)
         for (int c = 0; c < int'(ac); c++) begin
            v = $urandom;
            mem[2 + r * int'(ac) + c] = v;
            if (push) exp_q.push_back('{1'b0, 8'(r), 8'(c), v});
         end
      for (int r = 0; r < int'(br); r++)
         for (int c = 0; c < int'(bc); c++) begin
            v = $urandom;
            mem[10002 + r * int'(bc) + c] = v;
            if (push) exp_q.push_back('{1'b1, 8'(r), 8'(c), v});
         end
      beats = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input int d0);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt > d0 || (error && !busy)) begin
            ok = 1'b1;
            break;
         end
      end
      check("end_timeout", 32'(ok), 32'd1);
   endtask

   task automatic finish_ok(input logic [7:0] br, input logic [7:0] bc,
                            input logic [7:0] ar, input logic [7:0] ac,
                            input int d0, input int mode);
      int n;
      n = int'(ar) * int'(ac) + int'(br) * int'(bc);
      wait_end(d0);
      repeat (4) @(negedge clk);
      #1;
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("beats", 32'(beats), 32'(n));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("flag_cleared", mem[0], 32'd0);
      check("dims", {a_rows, a_cols, b_rows, b_cols}, {ar, ac, br, bc});
      check("dims_valid", 32'(dims_valid), 32'd1);
      check("error_low", 32'(error), 32'd0);
      check("busy_low", 32'(busy), 32'd0);
      if (mode == 0) check("no_gap", 32'(last_cyc - first_cyc), 32'(n - 1));
   endtask

   task automatic run_ok(input logic [7:0] br, input logic [7:0] bc,
                         input logic [7:0] ar, input logic [7:0] ac,
                         input int mode);
      int d0;
      ready_mode = mode;
      prep(br, bc, ar, ac, 32'd1, 1'b1);
      d0 = done_cnt;
      pulse_start();
      finish_ok(br, bc, ar, ac, d0, mode);
   endtask

   initial begin
      int d0, w0, v0, p0;
      logic [7:0] r1, c1, r2;
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outs",
            32'(|{mem_addr, mem_read, mem_we, mem_din, a_rows, a_cols,
                  b_rows, b_cols, dims_valid, elem_data, elem_sel,
                  elem_row, elem_col, elem_valid, busy, done, error}),
            32'd0);
      @(negedge clk);
      rst = 1'b0;

      // nominal, then backpressure, then random ready
      run_ok(8'd5, 8'd6, 8'd6, 8'd7, 0);
      run_ok(8'd5, 8'd6, 8'd6, 8'd7, 1);
      run_ok(8'd5, 8'd6, 8'd6, 8'd7, 2);
      run_ok(8'd1, 8'd1, 8'd1, 8'd1, 0);
      for (int k = 0; k < 3; k++) begin
         r1 = 8'($urandom_range(1, 5));
         c1 = 8'($urandom_range(1, 5));
         r2 = 8'($urandom_range(1, 5));
         run_ok(r2, r1, r1, c1, 2);
      end

      // dimension mismatch
      ready_mode = 0;
      prep(8'd5, 8'd5, 8'd6, 8'd7, 32'd1, 1'b0);
      w0 = flag_writes;
      v0 = valid_cnt;
      pulse_start();
      wait_end(done_cnt);
      repeat (3) @(negedge clk);
      #1;
      check("mm_error", 32'(error), 32'd1);
      check("mm_busy", 32'(busy), 32'd0);
      check("mm_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("mm_no_write", 32'(flag_writes - w0), 32'd0);
      check("mm_flag", mem[0], 32'd1);
      check("mm_dims_valid", 32'(dims_valid), 32'd0);

      // zero dimension
      prep(8'd5, 8'd0, 8'd0, 8'd7, 32'd1, 1'b0);
      pulse_start();
      wait_end(done_cnt);
      #1;
      check("zero_error", 32'(error), 32'd1);

      // flag late
      ready_mode = 0;
      prep(8'd5, 8'd6, 8'd6, 8'd7, 32'd0, 1'b1);
      d0 = done_cnt;
      p0 = poll_reads;
      pulse_start();
      repeat (20) @(negedge clk);
      mem[0] = 32'd1;
      finish_ok(8'd5, 8'd6, 8'd6, 8'd7, d0, 0);
      check("polls_min", 32'(poll_reads - p0 >= 20), 32'd1);
      check("polls_max", 32'(poll_reads - p0 <= 24), 32'd1);

      // reset mid-fetch
      ready_mode = 0;
      prep(8'd5, 8'd6, 8'd6, 8'd7, 32'd1, 1'b1);
      pulse_start();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (beats >= 10) break;
      end
      check("reached_beat10", 32'(beats >= 10), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_outs",
            32'(|{mem_addr, mem_read, mem_we, mem_din, a_rows, a_cols,
                  b_rows, b_cols, dims_valid, elem_data, elem_sel,
                  elem_row, elem_col, elem_valid, busy, done, error}),
            32'd0);
      check("rst_mid_flag", mem[0], 32'd1);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      run_ok(8'd5, 8'd6, 8'd6, 8'd7, 0);

      // start while busy
      ready_mode = 0;
      prep(8'd5, 8'd6, 8'd6, 8'd7, 32'd1, 1'b1);
      d0 = done_cnt;
      inject = 1'b1;
      pulse_start();
      finish_ok(8'd5, 8'd6, 8'd6, 8'd7, d0, 0);
      repeat (10) @(negedge clk);
      #1;
      check("busy_start_ignored", 32'(done_cnt - d0), 32'd1);
      check("busy_start_idle", 32'(busy), 32'd0);
      check("inject_fired", 32'(inject), 32'd0);

      check("rd_we_overlap", 32'(both_cnt), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
